// File: rtl/opb_register_simulink2ppc.sv
`default_nettype none
// ============================================================================
// opb_register_simulink2ppc
// Fabric-to-PPC snapshot register on OPB with unread flag, overrun counter
// and PPC-controlled freeze.
// Revision: 1.0
// ============================================================================
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01003800,
  parameter logic [31:0] C_HIGHADDR   = 32'h010038FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid,
  output logic                      user_new_data,
  output logic                      user_frozen
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_ack  = 1'b1;

  localparam logic [1:0] c_off_data   = 2'd0;
  localparam logic [1:0] c_off_status = 2'd1;
  localparam logic [1:0] c_off_ctrl   = 2'd2;

  localparam logic c_family_known = (C_FAMILY == "virtex5") ? 1'b1 : 1'b0;

  logic [0:0]  r_state;
  logic        r_xfer_ack;
  logic [31:0] r_rd_data;
  logic [31:0] r_snapshot;
  logic        r_new_data;
  logic [15:0] r_overrun;
  logic        r_freeze;

  logic        w_hit;
  logic        w_start;
  logic [1:0]  w_offset;
  logic        w_data_rd;
  logic        w_ctrl_wr;
  logic        w_clr_ovr;
  logic        w_capture;
  logic        w_overrun_evt;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_start  = (r_state == c_st_idle) && w_hit;
  assign w_offset = OPB_ABus[28:29];

  // Side effects fire only on the edge that enters ACK, never on a re-sampled select.
  assign w_data_rd = w_start && OPB_RNW && (w_offset == c_off_data);
  assign w_ctrl_wr = w_start && !OPB_RNW && (w_offset == c_off_ctrl) && OPB_BE[3];
  assign w_clr_ovr = w_ctrl_wr && OPB_DBus[30];

  assign w_capture     = user_data_valid && !r_freeze;
  assign w_overrun_evt = w_capture && r_new_data && !w_data_rd;

  always_comb begin
    w_rd_mux = '0;
    case (w_offset)
      c_off_data:   w_rd_mux = r_snapshot;
      c_off_status: w_rd_mux = {r_overrun, 15'd0, r_new_data};
      c_off_ctrl:   w_rd_mux = {31'd0, r_freeze};
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state    <= c_st_idle;
      r_xfer_ack <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_hit) begin
            r_state    <= c_st_ack;
            r_xfer_ack <= 1'b1;
            r_rd_data  <= OPB_RNW ? w_rd_mux : 32'd0;
          end
        end
        default: begin
          r_state    <= c_st_idle;
          r_xfer_ack <= 1'b0;
          r_rd_data  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_snapshot <= '0;
      r_new_data <= 1'b0;
      r_overrun  <= '0;
      r_freeze   <= 1'b0;
    end else begin
      // A capture wins over a same-edge DATA read: the flag stays set.
      if (w_capture) begin
        r_snapshot <= user_data_in;
        r_new_data <= 1'b1;
      end else if (w_data_rd) begin
        r_new_data <= 1'b0;
      end

      if (w_clr_ovr) begin
        r_overrun <= '0;
      end else if (w_overrun_evt && (r_overrun != 16'hFFFF)) begin
        r_overrun <= r_overrun + 16'd1;
      end

      if (w_ctrl_wr) begin
        r_freeze <= OPB_DBus[31];
      end
    end
  end

  assign Sl_DBus       = r_rd_data;
  assign Sl_xferAck    = r_xfer_ack;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_new_data = r_new_data;
  assign user_frozen   = r_freeze;

  assign w_unused = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], c_family_known};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc.sv
`default_nettype none
// Randomized bench for opb_register_simulink2ppc against a rule-level model
// of the snapshot, unread flag, overrun counter and freeze bit.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] c_base = 32'h01003800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus_in = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] ud = '0;
  logic        uv = 1'b0;
  logic        und, ufr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_snap = '0;
  bit          m_flag = 0;
  int          m_ovr = 0;
  bit          m_freeze = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus_in), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_data_in(ud), .user_data_valid(uv),
    .user_new_data(und), .user_frozen(ufr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = {m_ovr[15:0], 15'd0, m_flag};
    return s;
  endfunction

  // One clock edge of the register's rules.
  task automatic model_edge(input bit cap, input logic [31:0] v, input bit data_rd,
                            input bit clr, input bit ctrl_wr, input bit frz_val);
    bit overrun = 0;
    if (cap && !m_freeze) begin
      overrun = m_flag && !data_rd;
      m_snap  = v;
      m_flag  = 1;
    end else if (data_rd) begin
      m_flag = 0;
    end
    if (clr) m_ovr = 0;
    else if (overrun && m_ovr < 65535) m_ovr++;
    if (ctrl_wr) m_freeze = frz_val;
  endtask

  task automatic model_reset();
    m_snap = '0; m_flag = 0; m_ovr = 0; m_freeze = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_new_data"}, und, m_flag);
    check({tag, "_frozen"}, ufr, m_freeze);
  endtask

  task automatic xfer(input bit rnw_i, input logic [31:0] addr, input logic [3:0] be_i,
                      input logic [31:0] wd, input bit cap, input logic [31:0] capv,
                      output logic [31:0] rd);
    bit hit;
    logic [1:0] off;
    logic [31:0] exp_rd;
    bit ctrl_wr;
    @(negedge clk);
    check("pre_ack", sl_ack, 0);
    sel = 1; rnw = rnw_i; abus = addr; be = be_i; dbus_in = wd; uv = cap; ud = capv;
    hit = (addr >= c_base) && (addr <= c_base + 32'd255);
    off = addr[3:2];
    case (off)
      2'd0:    exp_rd = m_snap;
      2'd1:    exp_rd = m_status();
      2'd2:    exp_rd = {31'd0, m_freeze};
      default: exp_rd = 32'd0;
    endcase
    ctrl_wr = hit && !rnw_i && off == 2'd2 && be_i[0];
    model_edge(cap, capv, hit && rnw_i && off == 2'd0, ctrl_wr && wd[1], ctrl_wr, wd[0]);
    @(negedge clk);
    rd = sl_dbus;
    check("ack", sl_ack, hit);
    if (hit && rnw_i) check("rdata", rd, exp_rd);
    if (!hit) check("nohit_dbus", rd, 0);
    check_outputs("xfer");
    sel = 0; uv = 0; rnw = 0; dbus_in = '0;
    @(negedge clk);
    check("post_ack", sl_ack, 0);
    check("post_dbus", sl_dbus, 0);
  endtask

  task automatic capture_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uv = 1; ud = $urandom;
      model_edge(1, ud, 0, 0, 0, 0);
    end
    @(negedge clk);
    uv = 0;
    check_outputs("capture");
  endtask

  task automatic capture(input logic [31:0] v);
    @(negedge clk);
    uv = 1; ud = v;
    model_edge(1, v, 0, 0, 0, 0);
    @(negedge clk);
    uv = 0;
    check_outputs("capture");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    check("rst_ack", sl_ack, 0);
    check("rst_dbus", sl_dbus, 0);
    check("rst_new_data", und, 0);
    check("rst_frozen", ufr, 0);
    check("rst_consts", {sl_err, sl_retry, sl_tout}, 0);
    rst_n = 1;

    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("rst_status", rd, 32'h0);
    xfer(1, c_base + 8, 4'hF, 0, 0, 0, rd);   check("rst_ctrl", rd, 32'h0);

    capture(32'hDEADBEEF);
    check("cap_new_data", und, 1);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("cap_status", rd, 32'h1);
    xfer(1, c_base,     4'hF, 0, 0, 0, rd);   check("cap_data", rd, 32'hDEADBEEF);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("read_clears", rd, 32'h0);

    capture(32'h1); capture(32'h2); capture(32'h3);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("ovr_two", rd, 32'h00020001);
    xfer(0, c_base + 8, 4'hF, 32'h2, 0, 0, rd);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("ovr_clear", rd, 32'h00000001);
    xfer(1, c_base + 8, 4'hF, 0, 0, 0, rd);   check("clr_reads0", rd, 32'h0);

    capture_burst(32'h10005);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("ovr_sat", rd, 32'hFFFF0001);

    xfer(0, c_base + 8, 4'hF, 32'h1, 0, 0, rd);
    check("frozen", ufr, 1);
    held = m_snap;
    capture(32'h12345678);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);   check("frz_status", rd, 32'hFFFF0001);
    xfer(1, c_base,     4'hF, 0, 0, 0, rd);   check("frz_data", rd, held);
    xfer(0, c_base + 8, 4'b1110, 32'h0, 0, 0, rd);
    check("be_ignored", ufr, 1);
    xfer(0, c_base + 8, 4'hF, 32'h2, 0, 0, rd);

    capture(32'h5);
    xfer(1, c_base,     4'hF, 0, 1, 32'hA, rd); check("same_edge_data", rd, 32'h5);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);     check("same_edge_status", rd, 32'h00000001);
    xfer(1, c_base,     4'hF, 0, 0, 0, rd);     check("same_edge_next", rd, 32'hA);

    capture(32'h77);
    xfer(1, c_base + 32'h100, 4'hF, 0, 0, 0, rd);
    xfer(0, c_base - 4, 4'hF, 32'h3, 0, 0, rd);
    xfer(1, c_base + 12, 4'hF, 0, 0, 0, rd);    check("off_c_read", rd, 32'h0);
    xfer(0, c_base + 12, 4'hF, 32'hFFFF_FFFF, 0, 0, rd);
    xfer(1, c_base + 4, 4'hF, 0, 0, 0, rd);     check("off_c_status", rd, 32'h1);

    // Reset asserted while the ack is high must drop it without waiting for a clock.
    @(negedge clk);
    sel = 1; rnw = 1; abus = c_base + 4; be = 4'hF;
    @(posedge clk);
    #2 rst_n = 0;
    #1 check("rst_during_ack", sl_ack, 0);
    sel = 0;
    model_reset();
    @(negedge clk);
    check("rst_mid_dbus", sl_dbus, 0);
    check_outputs("rst_mid");
    rst_n = 1;

    for (int it = 0; it < 400; it++) begin
      bit c;
      c = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: capture($urandom);
        1: xfer(1, c_base + $urandom_range(0, 3), 4'hF, 0, c, $urandom, rd);
        2: xfer(1, c_base + 4 + $urandom_range(0, 3), 4'hF, 0, c, $urandom, rd);
        3: xfer(0, c_base + 8, 4'($urandom_range(0, 15)),
                {$urandom_range(0, 1) ? 30'h0 : 30'($urandom), 2'($urandom_range(0, 3))},
                c, $urandom, rd);
        4: xfer(1'($urandom_range(0, 1)), c_base + 12, 4'hF, $urandom, c, $urandom, rd);
        5: begin
          addr = $urandom_range(0, 1) ? c_base - 32'd1 - $urandom_range(0, 4000)
                                      : c_base + 32'd256 + $urandom_range(0, 4000);
          xfer(1'($urandom_range(0, 1)), addr, 4'hF, 32'h3, c, $urandom, rd);
        end
        default: xfer(1, c_base + 8, 4'hF, 0, c, $urandom, rd);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
